// File: rtl/i_mem_burst_responder.sv
// i_mem_burst_responder: memory end of the icache AR/R burst channel, with backdoor preload port.
// Define IMEM_RESP_STALL_EN to insert a one-cycle rvalid gap after every accepted non-last beat.
module i_mem_burst_responder #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h1fc0_0000,
  parameter int          FIRST_LAT  = 2,
  parameter string       INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           araddr,
  input  logic [3:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_waddr,
  input  logic [31:0]           mem_wdata
);

  // Handshakes: a transfer happens on the posedge where valid and ready are both high;
  // the source holds its payload stable until then, and ready never depends on a later valid.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(FIRST_LAT - 1);

  // The image is loaded through mem_we; the file name is kept only for instantiation compatibility.
  localparam bit unused_init_file = (INIT_FILE != "");

  state_t                state;
  state_t                state_d;
  logic [31:0]           mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [ADDR_WIDTH-1:0] idx_d;
  logic [3:0]            len_q;
  logic [3:0]            lat_q;
  logic [3:0]            beat_q;
  logic [3:0]            beat_d;
  logic                  err_q;
  logic                  ar_hs;
  logic                  accept;
  logic                  present;
  logic                  req_err;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^araddr[1:0];

  assign arready = (state == S_IDLE) && !rst;
  assign ar_hs   = arvalid && arready;
  assign rvalid  = (state == S_BURST);
  assign accept  = rvalid && rready;
  assign req_err = (arsize != 3'b010) ||
                   (araddr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2]);

  always_comb begin
    state_d = state;
    present = 1'b0;
    // Index/beat of the beat to present next; the index wraps inside the region.
    idx_d   = accept ? idx_q + ADDR_WIDTH'(1) : idx_q;
    beat_d  = accept ? beat_q + 4'd1 : beat_q;
    case (state)
      S_IDLE: begin
        if (ar_hs) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lat_q == 4'd0) begin
          state_d = S_BURST;
          present = 1'b1;
        end
      end
      S_BURST: begin
        if (accept) begin
          if (rlast) begin
            state_d = S_IDLE;
          end else begin
`ifdef IMEM_RESP_STALL_EN
            state_d = S_GAP;
`else
            present = 1'b1;
`endif
          end
        end
      end
      S_GAP: begin
        state_d = S_BURST;
        present = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      idx_q  <= '0;
      len_q  <= '0;
      lat_q  <= '0;
      beat_q <= '0;
      err_q  <= 1'b0;
      rdata  <= '0;
      rresp  <= 2'b00;
      rlast  <= 1'b0;
    end else begin
      state <= state_d;
      if (ar_hs) begin
        idx_q  <= araddr[ADDR_WIDTH+1:2];
        len_q  <= arlen;
        err_q  <= req_err;
        lat_q  <= LAT_INIT;
        beat_q <= '0;
      end else begin
        idx_q  <= idx_d;
        beat_q <= beat_d;
        if (state == S_WAIT && lat_q != 4'd0) lat_q <= lat_q - 4'd1;
      end
      // mem read here sees the pre-edge word, so a same-edge backdoor write is not visible yet.
      if (present) begin
        rdata <= err_q ? 32'h0 : mem[idx_d];
        rresp <= err_q ? 2'b10 : 2'b00;
        rlast <= (beat_d == len_q);
      end else if (accept && rlast) begin
        rlast <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_i_mem_burst_responder.sv
// Directed bench for i_mem_burst_responder: vector table of bursts plus hand-written
// read-before-write and reset-mid-burst sequences; honours IMEM_RESP_STALL_EN when defined.
module tb_i_mem_burst_responder;

  localparam int          AW   = 12;
  localparam logic [31:0] BASE = 32'h1fc0_0000;
  localparam int          LAT  = 2;
`ifdef IMEM_RESP_STALL_EN
  localparam int EXP_GAP = 1;
`else
  localparam int EXP_GAP = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   araddr;
  logic [3:0]    arlen;
  logic [2:0]    arsize;
  logic          arvalid;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  // clock / reset
  always #5 clk = ~clk;

  i_mem_burst_responder #(
    .ADDR_WIDTH(AW),
    .BASE_ADDR (BASE),
    .FIRST_LAT (LAT),
    .INIT_FILE ("")
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .araddr   (araddr),
    .arlen    (arlen),
    .arsize   (arsize),
    .arvalid  (arvalid),
    .arready  (arready),
    .rdata    (rdata),
    .rresp    (rresp),
    .rlast    (rlast),
    .rvalid   (rvalid),
    .rready   (rready),
    .mem_we   (mem_we),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [3:0]  rpat;
    bit          keep_ar;
    logic [1:0]  resp;
    logic [31:0] d0;
    logic [31:0] dlast;
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_mem [2**AW];
  logic [31:0] exp_q[$];
  vec_t        vecs [10];

  // scoreboard
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic note_timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got timeout want response", name);
  endtask

  // Consumes the queued beats; call just after a negedge with the burst under way.
  task automatic drain(input logic [3:0] rpat, input bit keep_ar, input logic [1:0] resp);
    int          steps   = 0;
    int          cyc     = 0;
    int          gap     = 0;
    bit          acc_prev = 1'b0;
    logic [31:0] want;
    while (exp_q.size() > 0) begin
      if (steps > 200) begin
        note_timeout("drain");
        exp_q.delete();
        break;
      end
      if (keep_ar) check("arready_busy", 32'(arready), 32'd0);
      if (rvalid) begin
        if (acc_prev) check("beat_gap", 32'(gap), 32'(EXP_GAP));
        acc_prev = 1'b0;
        want = exp_q[0];
        check("rdata", rdata, want);
        check("rresp", 32'(rresp), 32'(resp));
        check("rlast", 32'(rlast), 32'(exp_q.size() == 1));
        rready = rpat[cyc % 4];
        cyc++;
        if (rready) begin
          void'(exp_q.pop_front());
          acc_prev = 1'b1;
          gap = 0;
        end
      end else begin
        gap++;
        rready = 1'b0;
      end
      @(negedge clk);
      steps++;
    end
    rready = 1'b0;
    check("rvalid_after_last", 32'(rvalid), 32'd0);
    check("arready_after_last", 32'(arready), 32'd1);
  endtask

  // driver
  task automatic do_burst(input vec_t v, input logic [31:0] next_addr, input logic [3:0] next_len);
    logic [AW-1:0] idx;
    bit            err;
    int            k;
    err = (v.resp != 2'b00);
    idx = v.addr[AW+1:2];
    exp_q.delete();
    for (int b = 0; b <= int'(v.len); b++) begin
      if (b == 0)                exp_q.push_back(v.d0);
      else if (b == int'(v.len)) exp_q.push_back(v.dlast);
      else                       exp_q.push_back(err ? 32'h0 : exp_mem[idx + AW'(b)]);
    end
    check("arready_idle", 32'(arready), 32'd1);
    araddr  = v.addr;
    arlen   = v.len;
    arsize  = v.size;
    arvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (v.keep_ar) begin
      araddr = next_addr;
      arlen  = next_len;
      arsize = 3'b010;
    end else begin
      arvalid = 1'b0;
    end
    k = 0;
    while (!rvalid && k < 20) begin
      if (v.keep_ar) check("arready_wait", 32'(arready), 32'd0);
      @(negedge clk);
      k++;
    end
    check("first_lat", 32'(k), 32'(LAT));
    if (rvalid) drain(v.rpat, v.keep_ar, v.resp);
    else exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int steps;
    int nxt;
    rst = 1'b1;
    araddr = '0; arlen = '0; arsize = '0; arvalid = 1'b0; rready = 1'b0;
    mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rlast", 32'(rlast), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rresp", 32'(rresp), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_arready", 32'(arready), 32'd1);
    check("idle_rvalid", 32'(rvalid), 32'd0);

    for (int i = 0; i < 2**AW; i++) begin
      mem_we    = 1'b1;
      mem_waddr = AW'(i);
      mem_wdata = 32'h100 + i;
      exp_mem[i] = 32'h100 + i;
      @(negedge clk);
    end
    mem_we = 1'b0;

    //            addr          len    size    rpat     keep  resp   d0            dlast
    vecs[0] = '{32'h1fc0_0000, 4'd7,  3'b010, 4'b1111, 1'b0, 2'b00, 32'h0000_0100, 32'h0000_0107};
    vecs[1] = '{32'h1fc0_3ff8, 4'd3,  3'b010, 4'b1111, 1'b0, 2'b00, 32'h0000_10fe, 32'h0000_0101};
    vecs[2] = '{32'h1fc0_0040, 4'd1,  3'b001, 4'b1111, 1'b0, 2'b10, 32'h0000_0000, 32'h0000_0000};
    vecs[3] = '{32'h0000_0000, 4'd1,  3'b010, 4'b1111, 1'b0, 2'b10, 32'h0000_0000, 32'h0000_0000};
    vecs[4] = '{32'h1fc0_0100, 4'd0,  3'b010, 4'b1111, 1'b0, 2'b00, 32'h0000_0140, 32'h0000_0140};
    vecs[5] = '{32'h1fc0_3ffc, 4'd15, 3'b010, 4'b1111, 1'b0, 2'b00, 32'h0000_10ff, 32'h0000_010e};
    vecs[6] = '{32'h1fc0_0023, 4'd2,  3'b010, 4'b1001, 1'b0, 2'b00, 32'h0000_0108, 32'h0000_010a};
    vecs[7] = '{32'h1fc0_4000, 4'd2,  3'b010, 4'b1111, 1'b0, 2'b10, 32'h0000_0000, 32'h0000_0000};
    vecs[8] = '{32'h1fc0_0010, 4'd3,  3'b010, 4'b0101, 1'b1, 2'b00, 32'h0000_0104, 32'h0000_0107};
    vecs[9] = '{32'h1fc0_0200, 4'd1,  3'b010, 4'b1111, 1'b0, 2'b00, 32'h0000_0180, 32'h0000_0181};

    for (int i = 0; i < 10; i++) begin
      nxt = (i < 9) ? i + 1 : i;
      do_burst(vecs[i], vecs[nxt].addr, vecs[nxt].len);
    end

    // Backdoor write landing on the same edge as beat 0 returns the old word.
    check("rbw_arready", 32'(arready), 32'd1);
    araddr = BASE + 32'h40; arlen = 4'd3; arsize = 3'b010; arvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    @(negedge clk);
    check("rbw_rvalid_early", 32'(rvalid), 32'd0);
    mem_we = 1'b1; mem_waddr = AW'(16); mem_wdata = 32'hcafe_0010;
    @(negedge clk);
    check("rbw_rvalid", 32'(rvalid), 32'd1);
    check("rbw_old_word", rdata, 32'h0000_0110);
    check("rbw_rlast", 32'(rlast), 32'd0);
    mem_waddr = AW'(18); mem_wdata = 32'hcafe_0012;
    rready = 1'b1;
    @(negedge clk);
    mem_we = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'h0000_0111);
    exp_q.push_back(32'hcafe_0012);
    exp_q.push_back(32'h0000_0113);
    drain(4'b1111, 1'b0, 2'b00);
    exp_mem[16] = 32'hcafe_0010;
    exp_mem[18] = 32'hcafe_0012;
    do_burst('{32'h1fc0_0040, 4'd3, 3'b010, 4'b1111, 1'b0, 2'b00, 32'hcafe_0010, 32'h0000_0113},
             32'h0, 4'd0);

    // Reset on the third beat of an 8-beat burst.
    check("rstb_arready", 32'(arready), 32'd1);
    araddr = BASE; arlen = 4'd7; arsize = 3'b010; arvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    steps = 0;
    while (n < 3 && steps < 100) begin
      if (rvalid) begin
        check("rstb_rdata", rdata, exp_mem[n]);
        if (n == 2) rst = 1'b1;
        rready = 1'b1;
        n++;
      end
      @(negedge clk);
      steps++;
    end
    if (n < 3) note_timeout("rstb_beats");
    check("rstb_rvalid", 32'(rvalid), 32'd0);
    check("rstb_rlast", 32'(rlast), 32'd0);
    check("rstb_arready_in_rst", 32'(arready), 32'd0);
    rst = 1'b0;
    rready = 1'b0;
    @(negedge clk);
    check("rstb_arready_after", 32'(arready), 32'd1);
    check("rstb_rvalid_after", 32'(rvalid), 32'd0);
    do_burst('{32'h1fc0_0080, 4'd3, 3'b010, 4'b1111, 1'b0, 2'b00, 32'h0000_0120, 32'h0000_0123},
             32'h0, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
